// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 32 x DATA_W architectural register file with a per-register
// pending scoreboard for RAW stall generation in decode.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-through on both
// read ports, and stall released in the write-back cycle).
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [4:0]        WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [4:0]        ReadRegister1,
    input  logic [4:0]        ReadRegister2,
    input  logic              use1,
    input  logic              use2,
    input  logic              issue_en,
    input  logic [4:0]        issue_dest,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              stall,
    output logic [31:0]       pending
);

    localparam logic [4:0] ZR = 5'(ZERO_REG);

    logic [31:0][DATA_W-1:0] regs;
    logic [31:0]             wr_dec;
    logic [31:0]             pending_q;
    logic [31:0]             pending_nxt;
    logic                    fwd1;
    logic                    fwd2;
    logic                    hit1;
    logic                    hit2;

    // 5:32 write decoder; XZR never receives a write enable
    always_comb begin
        wr_dec = '0;
        if (RegWrite && (WriteRegister != ZR)) begin
            wr_dec[WriteRegister] = 1'b1;
        end
    end

    // Enabled register cells, one per architectural register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (wr_dec[i]) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    // Write-back forwarding match, only meaningful when the bypass is built in
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        fwd1 = RegWrite && (WriteRegister == ReadRegister1);
        fwd2 = RegWrite && (WriteRegister == ReadRegister2);
`else
        fwd1 = 1'b0;
        fwd2 = 1'b0;
`endif
    end

    // Read ports: XZR reads zero, forwarded value wins over stored contents,
    // outputs forced to zero while reset is asserted
    always_comb begin
        ReadData1 = regs[ReadRegister1];
        ReadData2 = regs[ReadRegister2];
        if (fwd1) ReadData1 = WriteData;
        if (fwd2) ReadData2 = WriteData;
        if (ReadRegister1 == ZR) ReadData1 = '0;
        if (ReadRegister2 == ZR) ReadData2 = '0;
        if (!rst) begin
            ReadData1 = '0;
            ReadData2 = '0;
        end
    end

    // RAW hazard detection against the scoreboard
    always_comb begin
        hit1  = pending_q[ReadRegister1] && (ReadRegister1 != ZR) && !fwd1;
        hit2  = pending_q[ReadRegister2] && (ReadRegister2 != ZR) && !fwd2;
        stall = rst && ((use1 && hit1) || (use2 && hit2));
    end

    // Scoreboard next state: clear applied first so a same-index set overrides it
    always_comb begin
        pending_nxt = pending_q;
        if (RegWrite) begin
            pending_nxt[WriteRegister] = 1'b0;
        end
        if (issue_en && !stall && (issue_dest != ZR)) begin
            pending_nxt[issue_dest] = 1'b1;
        end
        pending_nxt[ZR] = 1'b0;
    end

    // Scoreboard state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_nxt;
        end
    end

    assign pending = pending_q;

endmodule
